rsnn_param_core: RTL and testbench

- Parametrised recurrent spiking neural network core; successor to the fixed 3-input/3-neuron RSNN top module.
- N_IN input spike lines drive N_NEU leaky integrate-and-fire neurons through a loadable input weight matrix and a recurrent weight matrix.
- Weights and threshold arrive on a one-bit serial parameter port.
- Sits directly under the chip top wrapper, which drives pins and enables.

---
 rtl/rsnn_pkg.sv | 45 ++++
 rtl/rsnn_lif_neuron.sv | 71 +++++++
 rtl/rsnn_param_core.sv | 131 +++++++++++++
 tb/tb_rsnn_param_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rsnn_pkg.sv
// Shared types and helpers for the parametrised RSNN core: FSM states, parameter-frame
// geometry and signed saturation.
package rsnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Total serial frame length: W_in, then W_rec, then THRESH.
  function automatic int unsigned param_bits(input int unsigned n_in, input int unsigned n_neu,
                                             input int unsigned ww, input int unsigned vw);
    return (n_in * n_neu + n_neu * n_neu) * ww + vw;
  endfunction

  // Bit offsets from the start of the frame (first bit shifted in = offset 0).
  function automatic int unsigned win_off(input int unsigned i, input int unsigned j,
                                          input int unsigned n_neu, input int unsigned ww);
    return (i * n_neu + j) * ww;
  endfunction

  function automatic int unsigned wrec_off(input int unsigned k, input int unsigned j,
                                           input int unsigned n_in, input int unsigned n_neu,
                                           input int unsigned ww);
    return (n_in * n_neu + k * n_neu + j) * ww;
  endfunction

  function automatic int unsigned thresh_off(input int unsigned n_in, input int unsigned n_neu,
                                             input int unsigned ww);
    return (n_in * n_neu + n_neu * n_neu) * ww;
  endfunction

  // Clamp a signed value into the signed vw-bit range.
  function automatic int sat_vw(input int x, input int unsigned vw);
    int hi;
    int lo;
    hi = (32'sd1 <<< (vw - 32'd1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/rsnn_lif_neuron.sv
// One leaky integrate-and-fire neuron: leak, weighted accumulate, saturate, threshold.
// Refractory hold-off after a spike is built only with RSNN_REFRACTORY_EN.
module rsnn_lif_neuron
  import rsnn_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned N_NEU      = 3,
  parameter int unsigned WW         = 4,
  parameter int unsigned VW         = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC_CYC = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          tick,
  input  logic [N_IN+N_NEU-1:0]         in_vec,
  input  logic [(N_IN+N_NEU)*WW-1:0]    weights,
  input  logic signed [VW-1:0]          thresh,
  output logic                          spike
);

  localparam int unsigned NS = N_IN + N_NEU;
  localparam int unsigned SW = VW + $clog2(NS) + 1;
  localparam int unsigned RW = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;

`ifdef RSNN_REFRACTORY_EN
  localparam logic [RW-1:0] REFRAC_LOAD = RW'(REFRAC_CYC);
`else
  // Counter is never armed, so it stays at zero and the neuron may fire every tick.
  localparam logic [RW-1:0] REFRAC_LOAD = '0;
`endif

  logic signed [VW-1:0] v;
  logic [RW-1:0]        refrac;
  logic signed [SW-1:0] acc;
  logic signed [VW-1:0] v_sat;
  logic                 fire_c;

  // Leaked membrane plus the weights of every active input/recurrent line.
  always_comb begin
    acc = SW'(v) - SW'(v >>> LEAK_SHIFT);
    for (int i = 0; i < int'(NS); i++) begin
      if (in_vec[i]) acc = acc + SW'(signed'(weights[i*WW +: WW]));
    end
    v_sat  = VW'(sat_vw(int'(acc), VW));
    fire_c = (v_sat >= thresh);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      v      <= '0;
      spike  <= 1'b0;
      refrac <= '0;
    end else if (tick) begin
      if (refrac != '0) begin
        refrac <= refrac - RW'(1);
        v      <= '0;
        spike  <= 1'b0;
      end else if (fire_c) begin
        v      <= '0;
        spike  <= 1'b1;
        refrac <= REFRAC_LOAD;
      end else begin
        v      <= v_sat;
        spike  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/rsnn_param_core.sv
// Parametrised RSNN core: serial parameter loader FSM, weight storage and N_NEU LIF neurons.
// Optional refractory period enabled by defining RSNN_REFRACTORY_EN.
module rsnn_param_core
  import rsnn_pkg::*;
#(
  parameter int unsigned N_IN       = 3,
  parameter int unsigned N_NEU      = 3,
  parameter int unsigned WW         = 4,
  parameter int unsigned VW         = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             system_enable,
  input  logic             spike_input_reg_enable,
  input  logic             RSNN_enable,
  input  logic [N_IN-1:0]  input_spikes,
  input  logic             data_in,
  input  logic             load_params,
  output logic [N_NEU-1:0] output_spikes,
  output logic             end_writing,
  output logic             data_written
);

  localparam int unsigned PB   = param_bits(N_IN, N_NEU, WW, VW);
  localparam int unsigned CW   = $clog2(PB + 1);
  localparam int unsigned NS   = N_IN + N_NEU;
  localparam int unsigned TOFF = thresh_off(N_IN, N_NEU, WW);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [PB-1:0]        sr, sr_d;
  logic                 data_written_d, end_writing_d;
  logic                 clear_c, tick_c;
  logic [N_IN-1:0]      in_q;
  logic signed [VW-1:0] thresh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sr           <= '0;
      data_written <= 1'b0;
      end_writing  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      sr           <= sr_d;
      data_written <= data_written_d;
      end_writing  <= end_writing_d;
    end
  end

  // Loader FSM; a new load request wins over a neuron tick in the same cycle.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    sr_d           = sr;
    data_written_d = data_written;
    end_writing_d  = end_writing;
    clear_c        = 1'b0;
    tick_c         = 1'b0;
    if (system_enable) begin
      end_writing_d = 1'b0;
      case (state)
        IDLE, RUN: begin
          if (load_params) begin
            state_d        = LOAD;
            cnt_d          = '0;
            data_written_d = 1'b0;
            clear_c        = 1'b1;
          end else if (state == RUN) begin
            tick_c = RSNN_enable & data_written;
          end
        end
        LOAD: begin
          if (load_params) begin
            sr_d  = {sr[PB-2:0], data_in};
            cnt_d = cnt + CW'(1);
            if (cnt == CW'(PB - 1)) begin
              end_writing_d  = 1'b1;
              data_written_d = 1'b1;
              state_d        = RUN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) in_q <= '0;
    else if (system_enable && spike_input_reg_enable) in_q <= input_spikes;
  end

  // First bit shifted in ends up at the MSB, so frame offset o sits at PB-1-o.
  assign thresh = sr[PB-1-TOFF -: VW];

  for (genvar j = 0; j < N_NEU; j++) begin : g_neu
    logic [NS*WW-1:0] col;
    for (genvar i = 0; i < N_IN; i++) begin : g_win
      localparam int unsigned OFF = win_off(i, j, N_NEU, WW);
      assign col[i*WW +: WW] = sr[PB-1-OFF -: WW];
    end
    for (genvar k = 0; k < N_NEU; k++) begin : g_wrec
      localparam int unsigned OFF = wrec_off(k, j, N_IN, N_NEU, WW);
      assign col[(N_IN+k)*WW +: WW] = sr[PB-1-OFF -: WW];
    end

    rsnn_lif_neuron #(
      .N_IN      (N_IN),
      .N_NEU     (N_NEU),
      .WW        (WW),
      .VW        (VW),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRAC_CYC(REFRAC_CYC)
    ) u_neuron (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear_c),
      .tick   (tick_c),
      .in_vec ({output_spikes, in_q}),
      .weights(col),
      .thresh (thresh),
      .spike  (output_spikes[j])
    );
  end

endmodule

// File: tb/tb_rsnn_param_core.sv
// Directed self-checking bench for rsnn_param_core (default parameters, 80-bit frame).
// Expectations follow RSNN_REFRACTORY_EN when the bench is built with that macro.
module tb_rsnn_param_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       system_enable;
  logic       spike_input_reg_enable;
  logic       RSNN_enable;
  logic [2:0] input_spikes;
  logic       data_in;
  logic       load_params;
  logic [2:0] output_spikes;
  logic       end_writing;
  logic       data_written;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  rsnn_param_core dut (
    .clk                   (clk),
    .reset                 (reset),
    .system_enable         (system_enable),
    .spike_input_reg_enable(spike_input_reg_enable),
    .RSNN_enable           (RSNN_enable),
    .input_spikes          (input_spikes),
    .data_in               (data_in),
    .load_params           (load_params),
    .output_spikes         (output_spikes),
    .end_writing           (end_writing),
    .data_written          (data_written)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] make_frame(input logic [2:0][2:0][3:0] win,
                                             input logic [2:0][2:0][3:0] wrec,
                                             input logic [7:0] th);
    logic [79:0] f;
    int pos;
    f = '0;
    pos = 79;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        f[pos -: 4] = win[i][j];
        pos -= 4;
      end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++) begin
        f[pos -: 4] = wrec[k][j];
        pos -= 4;
      end
    f[7:0] = th;
    return f;
  endfunction

  // One entry cycle, then 80 data bits (optional pause before bit pause_at).
  task automatic load_frame(input logic [79:0] f, input int pause_at, input int pause_len,
                            input int exp_lat, input string tag);
    int   start;
    logic early;
    logic seen;
    early = 1'b0;
    seen  = 1'b0;
    @(negedge clk);
    start = cyc_cnt;
    load_params = 1'b1;
    data_in = 1'b0;
    for (int b = 0; b < 80; b++) begin
      if (b == pause_at) begin
        for (int p = 0; p < pause_len; p++) begin
          @(negedge clk);
          early |= end_writing;
          load_params = 1'b0;
        end
      end
      @(negedge clk);
      early |= end_writing;
      if (b == 0) begin
        check({tag, "_dw_low"}, 32'(data_written), 32'(1'b0));
        check({tag, "_cleared"}, 32'(output_spikes), 32'(3'b000));
        RSNN_enable = 1'b0;
      end
      load_params = 1'b1;
      data_in = f[79-b];
    end
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      load_params = 1'b0;
      if (end_writing) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ew_seen"}, 32'(seen), 32'(1'b1));
    check({tag, "_ew_latency"}, 32'(cyc_cnt - start), 32'(exp_lat));
    check({tag, "_ew_early"}, 32'(early), 32'(1'b0));
    check({tag, "_dw_high"}, 32'(data_written), 32'(1'b1));
    @(negedge clk);
    check({tag, "_ew_drop"}, 32'(end_writing), 32'(1'b0));
  endtask

  logic [2:0][2:0][3:0] wa, ra, wc, rc;
  logic [79:0] fa, fc;
  logic [2:0] exp_a [6];
  logic [2:0] exp_c [4];

  initial begin
`ifdef RSNN_REFRACTORY_EN
    exp_a = '{3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b101};
    exp_c = '{3'b001, 3'b010, 3'b000, 3'b001};
`else
    exp_a = '{3'b000, 3'b101, 3'b000, 3'b101, 3'b000, 3'b101};
    exp_c = '{3'b001, 3'b011, 3'b011, 3'b011};
`endif
    wa = '0; ra = '0; wc = '0; rc = '0;
    wa[0][0] = 4'd4; wa[1][1] = 4'd4; wa[2][2] = 4'd4;
    wc[0][0] = 4'd7; wc[1][0] = 4'd7; wc[2][0] = 4'd7;
    rc[0][1] = 4'd7;
    fa = make_frame(wa, ra, 8'd8);
    fc = make_frame(wc, rc, 8'd7);

    reset = 1'b1;
    system_enable = 1'b1;
    spike_input_reg_enable = 1'b0;
    RSNN_enable = 1'b0;
    input_spikes = '0;
    data_in = 1'b0;
    load_params = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(output_spikes), 32'(3'b000));
    check("rst_ew", 32'(end_writing), 32'(1'b0));
    check("rst_dw", 32'(data_written), 32'(1'b0));
    reset = 1'b0;

    // Threshold is 0 after reset, so any tick here would fire.
    RSNN_enable = 1'b1;
    spike_input_reg_enable = 1'b1;
    input_spikes = 3'b111;
    repeat (4) @(negedge clk);
    check("notick_out", 32'(output_spikes), 32'(3'b000));
    check("notick_dw", 32'(data_written), 32'(1'b0));
    RSNN_enable = 1'b0;
    input_spikes = 3'b101;

    load_frame(fa, -1, 0, 81, "load_a");
    RSNN_enable = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      check($sformatf("diag_tick%0d", t + 1), 32'(output_spikes), 32'(exp_a[t]));
    end

    RSNN_enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_rsnn_off", 32'(output_spikes), 32'(3'b101));
    end

    system_enable = 1'b0;
    RSNN_enable = 1'b1;
    load_params = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("hold_sys_off", 32'(output_spikes), 32'(3'b101));
      check("hold_sys_dw", 32'(data_written), 32'(1'b1));
    end
    load_params = 1'b0;
    system_enable = 1'b1;
    @(negedge clk);
    check("diag_tick7", 32'(output_spikes), 32'(3'b000));

    // Reload from RUN with the network enabled: load must win and clear the neurons.
    load_frame(fa, 40, 10, 91, "load_pause");
    RSNN_enable = 1'b1;
    @(negedge clk);
    check("reload_tick1", 32'(output_spikes), 32'(3'b000));
    @(negedge clk);
    check("reload_tick2", 32'(output_spikes), 32'(3'b101));

    RSNN_enable = 1'b0;
    input_spikes = 3'b001;
    load_frame(fc, -1, 0, 81, "load_rec");
    RSNN_enable = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check($sformatf("rec_tick%0d", t + 1), 32'(output_spikes), 32'(exp_c[t]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
